// File: rtl/cpu_pkg.sv
// Shared CPU-wide sizes and types for the register file and its write decoder.
package cpu_pkg;

   localparam int REG_COUNT      = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int WORD_WIDTH     = 32;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [WORD_WIDTH-1:0]     word_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/decoder_5_to_32.sv
// Binary-to-one-hot decoder: expands a 5-bit register index into 32 select lines.
module decoder_5_to_32
   import cpu_pkg::*;
(
   input  reg_addr_t              i_address,
   output logic [REG_COUNT-1:0]   o_onehot
);

   always_comb begin
      o_onehot            = '0;
      o_onehot[i_address] = 1'b1;
   end

endmodule

// File: rtl/register_file_32x32.sv
// 32 x DATA_WIDTH MIPS register file: two combinational read ports, one clocked write port,
// $0 hardwired to zero, optional same-cycle write-to-read bypass.
module register_file_32x32
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = WORD_WIDTH,
   parameter bit BYPASS     = 1'b1
)(
   input  logic                  clock,
   input  logic                  reset,
   input  reg_addr_t             read_address_a,
   input  reg_addr_t             read_address_b,
   output logic [DATA_WIDTH-1:0] read_data_a,
   output logic [DATA_WIDTH-1:0] read_data_b,
   input  logic                  write_enable,
   input  reg_addr_t             write_address,
   input  logic [DATA_WIDTH-1:0] write_data
);

   logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
   logic [REG_COUNT-1:0]  w_decoded;
   logic [REG_COUNT-1:0]  w_write_select;
   logic                  w_bypass_a;
   logic                  w_bypass_b;
   logic                  w_write_live;

   decoder_5_to_32 u_write_decoder (
      .i_address (write_address),
      .o_onehot  (w_decoded)
   );

   // Slot 0 is masked off so $0 can never be loaded, whatever the decoder says.
   always_comb begin
      w_write_select           = w_decoded & {REG_COUNT{write_enable}};
      w_write_select[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < REG_COUNT; i++) begin
         if (reset) begin
            r_regs[i] <= '0;
         end else if (w_write_select[i]) begin
            r_regs[i] <= write_data;
         end
      end
   end

   // Bypass is held off during reset so reads show stored contents, not the doomed write.
   assign w_write_live = BYPASS && !reset && write_enable && (write_address != ZERO_REG);
   assign w_bypass_a   = w_write_live && (read_address_a == write_address);
   assign w_bypass_b   = w_write_live && (read_address_b == write_address);

   always_comb begin
      read_data_a = r_regs[read_address_a];
      if (read_address_a == ZERO_REG) begin
         read_data_a = '0;
      end else if (w_bypass_a) begin
         read_data_a = write_data;
      end
   end

   always_comb begin
      read_data_b = r_regs[read_address_b];
      if (read_address_b == ZERO_REG) begin
         read_data_b = '0;
      end else if (w_bypass_b) begin
         read_data_b = write_data;
      end
   end

endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench: a bypass and a non-bypass instance share stimulus and are compared
// every cycle against an array model, plus hand-computed literal checks.
module tb_register_file_32x32;

   logic        clock;
   logic        reset;
   logic [4:0]  readAddressA;
   logic [4:0]  readAddressB;
   logic        writeEnable;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic [31:0] bypReadA, bypReadB, rawReadA, rawReadB;

   int assertCount  = 0;
   int failureCount = 0;

   logic [31:0] model [32];
   bit          modelValid = 1'b0;

   register_file_32x32 #(.DATA_WIDTH(32), .BYPASS(1'b1)) dutBypass (
      .clock          (clock),
      .reset          (reset),
      .read_address_a (readAddressA),
      .read_address_b (readAddressB),
      .read_data_a    (bypReadA),
      .read_data_b    (bypReadB),
      .write_enable   (writeEnable),
      .write_address  (writeAddress),
      .write_data     (writeData)
   );

   register_file_32x32 #(.DATA_WIDTH(32), .BYPASS(1'b0)) dutNoBypass (
      .clock          (clock),
      .reset          (reset),
      .read_address_a (readAddressA),
      .read_address_b (readAddressB),
      .read_data_a    (rawReadA),
      .read_data_b    (rawReadB),
      .write_enable   (writeEnable),
      .write_address  (writeAddress),
      .write_data     (writeData)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Architectural state: reset wipes everything, otherwise a non-zero target takes the data.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         modelValid = 1'b1;
      end else if (writeEnable && writeAddress != 5'd0) begin
         model[writeAddress] = writeData;
      end
   end

   function automatic logic [31:0] expectedRead(input logic [4:0] addr, input bit bypassOn);
      if (addr == 5'd0) return 32'h0;
      if (bypassOn && !reset && writeEnable && writeAddress == addr) return writeData;
      return model[addr];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failureCount++;
         $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Continuous comparison of all four read ports against the model.
   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("cmp_bypass_a",   bypReadA, expectedRead(readAddressA, 1'b1));
         checkOutput("cmp_bypass_b",   bypReadB, expectedRead(readAddressB, 1'b1));
         checkOutput("cmp_nobypass_a", rawReadA, expectedRead(readAddressA, 1'b0));
         checkOutput("cmp_nobypass_b", rawReadB, expectedRead(readAddressB, 1'b0));
      end
   end

   task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
      @(posedge clock);
      #1;
      reset        = rst;
      writeEnable  = we;
      writeAddress = wa;
      writeData    = wd;
      readAddressA = ra;
      readAddressB = rb;
   endtask

   initial begin
      reset        = 1'b1;
      writeEnable  = 1'b0;
      writeAddress = 5'd0;
      writeData    = 32'h0;
      readAddressA = 5'd0;
      readAddressB = 5'd0;

      // Reset clear
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
      @(negedge clock) checkOutput("preload_bypass", bypReadA, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      @(negedge clock) checkOutput("reset_cycle_stored", rawReadA, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      @(negedge clock) checkOutput("after_reset_r5", bypReadA, 32'h0);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         @(negedge clock);
         checkOutput("reset_sweep_a", bypReadA, 32'h0);
         checkOutput("reset_sweep_b", rawReadB, 32'h0);
      end

      // Basic write/read
      applyStimulus(1'b0, 1'b1, 5'd7,  32'h12345678, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0,  32'h0,        5'd7, 5'd31);
      @(negedge clock);
      checkOutput("basic_r7",  rawReadA, 32'h12345678);
      checkOutput("basic_r31", rawReadB, 32'hFFFFFFFF);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd30);
      @(negedge clock);
      checkOutput("basic_r8_zero",  rawReadA, 32'h0);
      checkOutput("basic_r30_zero", rawReadB, 32'h0);

      // $0 immutability
      applyStimulus(1'b0, 1'b1, 5'd0, 32'hCAFEF00D, 5'd0, 5'd0);
      @(negedge clock) checkOutput("r0_write_cycle", bypReadA, 32'h0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(negedge clock) checkOutput("r0_after_write", rawReadA, 32'h0);

      // Bypass versus no bypass
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h11111111, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h22222222, 5'd9, 5'd9);
      @(negedge clock);
      checkOutput("bypass_a",   bypReadA, 32'h22222222);
      checkOutput("bypass_b",   bypReadB, 32'h22222222);
      checkOutput("nobypass_a", rawReadA, 32'h11111111);
      checkOutput("nobypass_b", rawReadB, 32'h11111111);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      @(negedge clock);
      checkOutput("nobypass_next", rawReadA, 32'h22222222);

      // Back-to-back writes, last one wins
      applyStimulus(1'b0, 1'b1, 5'd12, 32'h00000001, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b1, 5'd12, 32'h00000002, 5'd0, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0,  32'h0,        5'd12, 5'd12);
      @(negedge clock) checkOutput("b2b_last_wins", rawReadA, 32'h00000002);

      // Write/reset collision
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hAAAA0000, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h5555FFFF, 5'd3, 5'd3);
      @(negedge clock) checkOutput("collision_no_bypass_in_reset", bypReadA, 32'hAAAA0000);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd12);
      @(negedge clock);
      checkOutput("collision_r3", bypReadA, 32'h0);
      checkOutput("collision_r12_cleared", bypReadB, 32'h0);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h5555FFFF, 5'd3, 5'd0);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      @(negedge clock) checkOutput("resume_after_reset", rawReadA, 32'h5555FFFF);

      // Exhaustive walk
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'd0);
      end
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         @(negedge clock);
         checkOutput("walk_a", rawReadA, 32'(i) * 32'h01010101);
         checkOutput("walk_b", bypReadB, 32'(31 - i) * 32'h01010101);
      end

      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
      $finish;
   end

endmodule
